// File: rtl/channel_err_inj_pkg.sv
// Shared types and helpers for the channel error injector: injection mode
// encoding, the Galois LFSR tap mask and a population count used to tally
// flipped bits.
package chan_pkg;

    typedef enum logic [1:0] {
        CLEAN    = 2'd0,
        PERIODIC = 2'd1,
        BURST    = 2'd2,
        RANDOM   = 2'd3
    } mode_e;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Number of set bits in a vector of up to 64 bits (zero-extend narrower masks).
    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/channel_err_inj_if.sv
// Symbol stream between the encoder side and the decoder side of the channel.
// Handshake: valid only, no ready. A symbol is transferred on every rising
// clk edge where valid_i is high; the channel can never stall it, and the
// corresponding valid_o/sym_o/err_o appear exactly one cycle later.
interface channel_err_inj_if #(
    parameter int W = 2
) ();
    logic         valid_i;
    logic [W-1:0] sym_i;
    logic         valid_o;
    logic [W-1:0] sym_o;
    logic         err_o;

    // Producer/consumer side (encoder in, decoder out).
    modport master (
        output valid_i, sym_i,
        input  valid_o, sym_o, err_o
    );

    // The channel itself.
    modport slave (
        input  valid_i, sym_i,
        output valid_o, sym_o, err_o
    );
endinterface

// File: rtl/channel_err_inj_lfsr32.sv
// 32-bit Galois LFSR. load (re)seeds it and wins over step; step advances
// it by one state. Reset also loads the seed so sequences are reproducible.
module lfsr32
    import chan_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] seed,
    output logic [31:0] q
);

    logic [31:0] q_next;

    // Right shift; feed the tap mask back when the bit shifted out is 1.
    always_comb begin
        q_next = {1'b0, q[31:1]} ^ (q[0] ? LFSR_TAPS : 32'd0);
    end

    // State register: seed on reset or load, advance on step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= seed;
        end else if (load) begin
            q <= seed;
        end else if (step) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/channel_err_inj.sv
// Channel model between convolutional encoder and Viterbi decoder. Each
// accepted symbol is forwarded one cycle later, optionally XORed with
// bit_mask_i according to the selected error pattern, and saturating
// counters track symbols carried and bits corrupted.
module channel_err_inj
    import chan_pkg::*;
#(
    parameter int          W         = 2,
    parameter int          PERIOD    = 8,
    parameter int          BURST_LEN = 2,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] SEED      = 32'hACE1_2B3C
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode_i,
    input  logic [W-1:0]       bit_mask_i,
    input  logic [7:0]         thresh_i,
    input  logic               clr_i,
    channel_err_inj_if.slave   sif,
    output logic [CNT_W-1:0]   sym_ct_o,
    output logic [CNT_W-1:0]   bad_bit_ct_o
);

    // Parameter sanity: these make the pattern logic meaningless.
    if (W < 1 || W > 64) begin : g_err_w
        $error("channel_err_inj: W must be in 1..64");
    end
    if (PERIOD < 1) begin : g_err_period
        $error("channel_err_inj: PERIOD must be >= 1");
    end
    if (BURST_LEN < 1 || BURST_LEN > PERIOD) begin : g_err_burst
        $error("channel_err_inj: BURST_LEN must be in 1..PERIOD");
    end

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam int          PW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    // Sum width wide enough for counter + popcount without overflow.
    localparam int          SW       = ((CNT_W > 7) ? CNT_W : 7) + 1;
    localparam logic [SW-1:0] CNT_MAX   = (SW'(1) << CNT_W) - SW'(1);
    localparam logic [PW:0]   BURST_LIM = (PW + 1)'(BURST_LEN);
    localparam logic [PW-1:0] POS_LAST  = PW'(PERIOD - 1);

    mode_e          mode;
    logic           accept;
    logic [31:0]    lfsr_q;
    logic [PW-1:0]  pos;
    logic [PW-1:0]  pos_next;
    logic           corrupt;
    logic [W-1:0]   mask;
    logic [6:0]     flip_n;
    logic [SW-1:0]  sym_sum;
    logic [SW-1:0]  bad_sum;
    logic [CNT_W-1:0] sym_ct_next;
    logic [CNT_W-1:0] bad_ct_next;

    logic           valid_q;
    logic [W-1:0]   sym_q;
    logic           err_q;

    assign mode   = mode_e'(mode_i);
    // clr_i takes priority: a symbol in a clear cycle is passed but not accepted.
    assign accept = sif.valid_i & ~clr_i;

    lfsr32 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (clr_i),
        .step (accept),
        .seed (SEED_EFF),
        .q    (lfsr_q)
    );

    // Corruption decision from the current pos/LFSR, before they advance.
    always_comb begin
        corrupt = 1'b0;
        case (mode)
            CLEAN:    corrupt = 1'b0;
            PERIODIC: corrupt = (pos == '0);
            BURST:    corrupt = ({1'b0, pos} < BURST_LIM);
            RANDOM:   corrupt = (lfsr_q[7:0] < thresh_i);
            default:  corrupt = 1'b0;
        endcase
        mask = corrupt ? bit_mask_i : '0;
    end

    // Next position and saturating counter updates.
    always_comb begin
        pos_next    = (pos == POS_LAST) ? '0 : pos + PW'(1);
        flip_n      = popcount(64'(mask));
        sym_sum     = SW'(sym_ct_o) + SW'(1);
        bad_sum     = SW'(bad_bit_ct_o) + SW'(flip_n);
        sym_ct_next = (sym_sum > CNT_MAX) ? '1 : sym_sum[CNT_W-1:0];
        bad_ct_next = (bad_sum > CNT_MAX) ? '1 : bad_sum[CNT_W-1:0];
    end

    // Output register, position and statistics: clear beats accept, idle holds sym.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q      <= 1'b0;
            sym_q        <= '0;
            err_q        <= 1'b0;
            pos          <= '0;
            sym_ct_o     <= '0;
            bad_bit_ct_o <= '0;
        end else if (clr_i) begin
            valid_q      <= sif.valid_i;
            err_q        <= 1'b0;
            if (sif.valid_i) begin
                sym_q <= sif.sym_i;
            end
            pos          <= '0;
            sym_ct_o     <= '0;
            bad_bit_ct_o <= '0;
        end else if (sif.valid_i) begin
            valid_q      <= 1'b1;
            sym_q        <= sif.sym_i ^ mask;
            err_q        <= |mask;
            pos          <= pos_next;
            sym_ct_o     <= sym_ct_next;
            bad_bit_ct_o <= bad_ct_next;
        end else begin
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end
    end

    assign sif.valid_o = valid_q;
    assign sif.sym_o   = sym_q;
    assign sif.err_o   = err_q;

endmodule

// File: tb/tb_channel_err_inj.sv
// Bench for channel_err_inj. Two instances share stimulus: a default one
// (PERIOD=8, BURST_LEN=2, CNT_W=16) and a small one (PERIOD=1, BURST_LEN=1,
// CNT_W=4, SEED=0) for saturation and zero-seed behaviour. Expected outputs
// come from a symbol-level model and are matched by a negedge monitor.
module tb_channel_err_inj;

    localparam int EW = 35;  // {sym[1:0], err, sym_ct[15:0], bad_ct[15:0]}

    logic clk;
    logic rst;
    logic [1:0] mode_i;
    logic [1:0] bit_mask_i;
    logic [7:0] thresh_i;
    logic clr_i;
    logic valid_i;
    logic [1:0] sym_i;

    logic [15:0] a_sym_ct, a_bad_ct;
    logic [3:0]  b_sym_ct, b_bad_ct;

    channel_err_inj_if #(.W(2)) if_a ();
    channel_err_inj_if #(.W(2)) if_b ();

    assign if_a.valid_i = valid_i;
    assign if_a.sym_i   = sym_i;
    assign if_b.valid_i = valid_i;
    assign if_b.sym_i   = sym_i;

    channel_err_inj #(.W(2), .PERIOD(8), .BURST_LEN(2), .CNT_W(16), .SEED(32'hACE1_2B3C)) dut_a (
        .clk(clk), .rst(rst), .mode_i(mode_i), .bit_mask_i(bit_mask_i), .thresh_i(thresh_i),
        .clr_i(clr_i), .sif(if_a), .sym_ct_o(a_sym_ct), .bad_bit_ct_o(a_bad_ct)
    );

    channel_err_inj #(.W(2), .PERIOD(1), .BURST_LEN(1), .CNT_W(4), .SEED(32'd0)) dut_b (
        .clk(clk), .rst(rst), .mode_i(mode_i), .bit_mask_i(bit_mask_i), .thresh_i(thresh_i),
        .clr_i(clr_i), .sif(if_b), .sym_ct_o(b_sym_ct), .bad_bit_ct_o(b_bad_ct)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];

    // ---------------- reference model ----------------
    int       P_PERIOD[2] = '{8, 1};
    int       P_BURST[2]  = '{2, 1};
    int       P_MAX[2]    = '{65535, 15};
    bit [31:0] P_SEED[2]  = '{32'hACE1_2B3C, 32'd1};

    int       m_n[2];
    bit [31:0] m_lfsr[2];
    int       m_sym[2];
    int       m_bad[2];

    function automatic bit [31:0] lfsr_step(input bit [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'd0);
    endfunction

    task automatic model_reset(input int d);
        m_n[d] = 0;
        m_lfsr[d] = P_SEED[d];
        m_sym[d] = 0;
        m_bad[d] = 0;
    endtask

    task automatic push_exp(input int d, input logic [EW-1:0] e);
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // One cycle of the channel for instance d, using the current inputs.
    task automatic model_step(input int d);
        int pos;
        bit hit;
        logic [1:0] m;
        if (clr_i) begin
            model_reset(d);
            if (valid_i) push_exp(d, {sym_i, 1'b0, 16'd0, 16'd0});
            return;
        end
        if (!valid_i) return;
        pos = m_n[d] % P_PERIOD[d];
        case (mode_i)
            2'd1:    hit = (pos == 0);
            2'd2:    hit = (pos < P_BURST[d]);
            2'd3:    hit = (m_lfsr[d][7:0] < thresh_i);
            default: hit = 1'b0;
        endcase
        m = hit ? bit_mask_i : 2'b00;
        m_lfsr[d] = lfsr_step(m_lfsr[d]);
        m_n[d]++;
        m_sym[d] = (m_sym[d] + 1 > P_MAX[d]) ? P_MAX[d] : m_sym[d] + 1;
        m_bad[d] = (m_bad[d] + $countones(m) > P_MAX[d]) ? P_MAX[d] : m_bad[d] + $countones(m);
        push_exp(d, {sym_i ^ m, |m, 16'(m_sym[d]), 16'(m_bad[d])});
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_out(input int d, input logic v, input logic [1:0] so, input logic eo,
                             input logic [15:0] sc, input logic [15:0] bc);
        logic [EW-1:0] e;
        int sz;
        if (v) begin
            sz = (d == 0) ? exp_q0.size() : exp_q1.size();
            if (sz == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL d%0d_unexpected_valid actual=1 required=0 (t=%0t)", d, $time);
            end else begin
                e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                chk($sformatf("d%0d_sym", d),    32'(so), 32'(e[34:33]));
                chk($sformatf("d%0d_err", d),    32'(eo), 32'(e[32]));
                chk($sformatf("d%0d_sym_ct", d), 32'(sc), 32'(e[31:16]));
                chk($sformatf("d%0d_bad_ct", d), 32'(bc), 32'(e[15:0]));
            end
        end else begin
            chk($sformatf("d%0d_idle_err", d), 32'(eo), 32'd0);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            check_out(0, if_a.valid_o, if_a.sym_o, if_a.err_o, a_sym_ct, a_bad_ct);
            check_out(1, if_b.valid_o, if_b.sym_o, if_b.err_o, 16'(b_sym_ct), 16'(b_bad_ct));
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+1; presents one cycle of inputs and updates the model.
    task automatic drive(input logic v, input logic [1:0] s, input logic c);
        valid_i = v;
        sym_i   = s;
        clr_i   = c;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        clr_i   = 1'b0;
    endtask

    task automatic check_reset_zero(input string tag);
        chk({tag, "_a_valid"},  32'(if_a.valid_o), 32'd0);
        chk({tag, "_a_sym"},    32'(if_a.sym_o),   32'd0);
        chk({tag, "_a_err"},    32'(if_a.err_o),   32'd0);
        chk({tag, "_a_sym_ct"}, 32'(a_sym_ct),     32'd0);
        chk({tag, "_a_bad_ct"}, 32'(a_bad_ct),     32'd0);
        chk({tag, "_b_valid"},  32'(if_b.valid_o), 32'd0);
        chk({tag, "_b_sym_ct"}, 32'(b_sym_ct),     32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        n_errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        mode_i = 2'd0;
        bit_mask_i = 2'b00;
        thresh_i = 8'd0;
        clr_i = 1'b0;
        valid_i = 1'b0;
        sym_i = 2'b00;
        model_reset(0);
        model_reset(1);

        // Reset held with valid toggling: outputs stay zero.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            valid_i = 1'($urandom_range(0, 1));
            sym_i   = 2'($urandom_range(0, 3));
            @(negedge clk);
            check_reset_zero("rst_hold");
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // CLEAN: 2'b11 passes through, counted once.
        mode_i = 2'd0;
        drive(1'b1, 2'b11, 1'b0);
        chk("clean_first_sym_ct", 32'(a_sym_ct), 32'd1);
        chk("clean_first_sym", 32'(if_a.sym_o), 32'd3);

        // PERIODIC: mask 10 on symbols 0 and 8.
        drive(1'b0, 2'b00, 1'b1);
        mode_i = 2'd1;
        bit_mask_i = 2'b10;
        for (int i = 0; i < 16; i++) drive(1'b1, 2'b00, 1'b0);
        chk("periodic_bad_ct", 32'(a_bad_ct), 32'd2);
        chk("periodic_sym_ct", 32'(a_sym_ct), 32'd16);

        // BURST: mask 11 on symbols 0,1,8,9, with random valid gaps.
        drive(1'b0, 2'b00, 1'b1);
        mode_i = 2'd2;
        bit_mask_i = 2'b11;
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 2) == 0) drive(1'b0, 2'($urandom_range(0, 3)), 1'b0);
            drive(1'b1, 2'b01, 1'b0);
        end
        chk("burst_bad_ct", 32'(a_bad_ct), 32'd8);
        chk("burst_sym_ct", 32'(a_sym_ct), 32'd16);

        // RANDOM, threshold 0: never corrupts.
        drive(1'b0, 2'b00, 1'b1);
        mode_i = 2'd3;
        thresh_i = 8'd0;
        for (int i = 0; i < 1000; i++) drive(1'b1, 2'($urandom_range(0, 3)), 1'b0);
        chk("random_t0_a_bad_ct", 32'(a_bad_ct), 32'd0);
        chk("random_t0_b_bad_ct", 32'(b_bad_ct), 32'd0);

        // RANDOM, threshold 128: positions follow the LFSR model.
        drive(1'b0, 2'b00, 1'b1);
        thresh_i = 8'd128;
        for (int i = 0; i < 1000; i++) drive(1'b1, 2'($urandom_range(0, 3)), 1'b0);

        // Saturation on the CNT_W=4 instance, then clear with a live symbol.
        drive(1'b0, 2'b00, 1'b1);
        mode_i = 2'd1;
        bit_mask_i = 2'b11;
        for (int i = 0; i < 10; i++) drive(1'b1, 2'($urandom_range(0, 3)), 1'b0);
        chk("sat_b_bad_ct", 32'(b_bad_ct), 32'd15);
        chk("sat_b_sym_ct", 32'(b_sym_ct), 32'd10);
        drive(1'b1, 2'b11, 1'b1);
        chk("clr_b_sym", 32'(if_b.sym_o), 32'd3);
        chk("clr_b_err", 32'(if_b.err_o), 32'd0);
        chk("clr_b_bad_ct", 32'(b_bad_ct), 32'd0);
        chk("clr_b_sym_ct", 32'(b_sym_ct), 32'd0);

        // Mixed random traffic: modes, masks, thresholds, gaps and clears.
        for (int i = 0; i < 400; i++) begin
            mode_i     = 2'($urandom_range(0, 3));
            bit_mask_i = 2'($urandom_range(0, 3));
            thresh_i   = 8'($urandom_range(0, 255));
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 31) == 0));
        end

        // Reset during the second symbol of a burst.
        drive(1'b0, 2'b00, 1'b1);
        mode_i = 2'd2;
        bit_mask_i = 2'b11;
        drive(1'b1, 2'b00, 1'b0);
        valid_i = 1'b1;
        sym_i = 2'b00;
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        @(negedge clk);
        check_reset_zero("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset(0);
        model_reset(1);
        chk("rst_mid_q0_empty", 32'(exp_q0.size()), 32'd0);
        chk("rst_mid_q1_empty", 32'(exp_q1.size()), 32'd0);
        for (int i = 0; i < 4; i++) drive(1'b1, 2'b00, 1'b0);
        chk("rst_mid_bad_ct", 32'(a_bad_ct), 32'd4);

        // Drain and report.
        for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, 1'b0);
        chk("final_q0_empty", 32'(exp_q0.size()), 32'd0);
        chk("final_q1_empty", 32'(exp_q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/channel_err_inj.md
# channel_err_inj

Parametrised, cycle-accurate channel model between the convolutional encoder and the Viterbi decoder in the term-project test harness. It passes one W-bit code symbol per valid cycle and deterministically or pseudo-randomly flips selected bits. Error patterns are clean, periodic single-symbol, burst, or LFSR-driven random. It keeps saturating counts of symbols carried and bits corrupted so benches can compare decoder output against injected error load.

## Interface
- W, 2, code symbol width in bits (≥1)
- PERIOD, 8, symbols per injection period (≥1)
- BURST_LEN, 2, corrupted symbols at the start of each period in BURST mode (1..PERIOD)
- CNT_W, 16, width of the statistics counters
- SEED, 32'hACE1_2B3C, LFSR reload value; 0 is replaced by 1
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- mode_i  in  2  0 CLEAN, 1 PERIODIC, 2 BURST, 3 RANDOM
- bit_mask_i  in  W  bits flipped in a corrupted symbol
- thresh_i  in  8  RANDOM mode: corrupt when lfsr[7:0] < thresh_i
- clr_i  in  1  synchronous clear of counters, position and LFSR
- valid_i  in  1  sym_i valid this cycle
- sym_i  in  W  encoder output symbol
- valid_o  out  1  sym_o valid
- sym_o  out  W  channel output symbol
- err_o  out  1  sym_o was corrupted (at least one bit flipped)
- sym_ct_o  out  CNT_W  symbols accepted since reset/clear, saturating
- bad_bit_ct_o  out  CNT_W  bits flipped since reset/clear, saturating

## Operation
- pos: position counter 0..PERIOD-1. Advances only on an accepted symbol (valid_i=1, clr_i=0) and wraps from PERIOD-1 to 0.
- The per-symbol mask uses the current pos/LFSR before they advance:
  - CLEAN: mask 0.
  - PERIODIC: bit_mask_i when pos==0.
  - BURST: bit_mask_i when pos<BURST_LEN.
  - RANDOM: bit_mask_i when lfsr[7:0]<thresh_i. thresh_i=0 means never corrupt.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (tap mask 32'h8020_0003). It steps once per accepted symbol in every mode, so RANDOM sequences are reproducible from SEED.
- Accepted symbol:
  - sym_o ← sym_i ^ mask; err_o ← |mask.
  - sym_ct += 1; bad_bit_ct += popcount(mask).
  - Both counters saturate at all-ones and never wrap.
- valid_i=0: valid_o←0, err_o←0, sym_o holds its last value, nothing advances.
- clr_i=1: counters←0, pos←0, LFSR←SEED. clr_i has priority over valid_i. A symbol presented in a clr_i cycle is still forwarded (valid_o=1) uncorrupted (err_o=0) and is not counted.
- mode_i, bit_mask_i and thresh_i are sampled per symbol. A change applies to the next accepted symbol. pos is not reset on a mode change.
- Elaboration errors: PERIOD<1, BURST_LEN<1, BURST_LEN>PERIOD, W<1.

## Timing
- Latency: exactly 1 cycle from valid_i/sym_i to valid_o/sym_o/err_o. Full throughput, one symbol per cycle, no backpressure.
- Counters update in the same edge as the output registers, so they reflect symbols up to and including the current sym_o.
- Reset (async, rst low) values:
  - valid_o=0, sym_o=0, err_o=0, sym_ct_o=0, bad_bit_ct_o=0.
  - pos=0, LFSR=SEED.
- Reset mid-stream: any in-flight symbol is dropped. The first symbol accepted after release sees pos=0 and LFSR=SEED.
- Saturation boundary: an increment that would exceed all-ones yields all-ones, including a multi-bit add near saturation.

## Structure
- Package chan_pkg: mode enum typedef (CLEAN, PERIODIC, BURST, RANDOM), LFSR tap constant, and popcount function.
- Sub-module lfsr32 (clk, rst, load, step, seed, q) holds the LFSR. All other logic stays in channel_err_inj.

## Test plan
- Reset: hold rst low with valid_i toggling → all outputs 0. After release, the first symbol 2'b11 in CLEAN mode appears one cycle later as 2'b11, sym_ct_o=1.
- PERIODIC, PERIOD=8, mask 2'b10, 16 symbols of 2'b00 → symbols 0 and 8 emerge as 2'b10 with err_o=1, all others 2'b00; bad_bit_ct_o=2, sym_ct_o=16.
- BURST, BURST_LEN=2, mask 2'b11, 16 symbols of 2'b01 → symbols 0, 1, 8, 9 emerge as 2'b10; bad_bit_ct_o=8. Gaps in valid_i do not shift the pattern.
- RANDOM, 1000 symbols, check thresh_i=0 and thresh_i=128:
  - thresh_i=0 → zero errors.
  - thresh_i=128 → corrupted positions exactly match a bench LFSR model seeded with SEED.
- Saturation and clear, CNT_W=4, PERIODIC, PERIOD=1, mask 2'b11, 10 symbols:
  - bad_bit_ct_o sticks at 15 and sym_ct_o reaches 10.
  - Then clr_i with valid_i=1 → both counters 0, that symbol forwarded unflipped.
- Reset mid-burst: assert rst during the second symbol of a burst → after release the pattern restarts at pos=0 with two corrupted symbols.
